// File: rtl/board_memory.sv
// board_memory: register file holding one CELL_W-bit cell per board position.
// Cell k lives at board[CELL_W*k +: CELL_W]; cell address is {y[3:0], x[3:0]}.
// Reads are combinational from the cell registers (no write-through).
// Optional build macro BOARD_MEMORY_OCCUPIED_GUARD_EN suppresses non-undo writes
// to occupied cells and reports each one with a one-cycle wr_blocked pulse.
module board_memory #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CELL_W = 2
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              we,
   input  logic [CELL_W-1:0]                 player,
   input  logic                              regret,
   input  logic [ADDR_W-1:0]                 wr_addr,
   input  logic [ADDR_W-1:0]                 rd_addr,
   output logic [CELL_W*(1 << ADDR_W)-1:0]   board,
   output logic [CELL_W-1:0]                 rd_data,
   output logic                              wr_blocked
);

   localparam int unsigned NCELLS = 1 << ADDR_W;

   logic [CELL_W-1:0] cells_q [NCELLS];
   logic [CELL_W-1:0] cells_d [NCELLS];
   logic              wr_blocked_q;
   logic              wr_blocked_d;
   logic [CELL_W-1:0] wr_data_c;
   logic              blocked_c;
   logic              wr_en_c;

   // Write data: undo clears the cell, otherwise store the player's stone.
   always_comb begin
      wr_data_c = regret ? '0 : player;
   end

   // Occupancy guard decision for the current write request.
   always_comb begin
      blocked_c = 1'b0;
`ifdef BOARD_MEMORY_OCCUPIED_GUARD_EN
      blocked_c = we && !regret && (cells_q[wr_addr] != '0);
`endif
      wr_en_c = we && !blocked_c;
   end

   // Next-state for the cell array and blocked flag; reset wins over a write.
   always_comb begin
      for (int unsigned k = 0; k < NCELLS; k++) begin
         cells_d[k] = cells_q[k];
      end
      wr_blocked_d = 1'b0;
      if (reset) begin
         for (int unsigned k = 0; k < NCELLS; k++) begin
            cells_d[k] = '0;
         end
      end else begin
         if (wr_en_c) begin
            cells_d[wr_addr] = wr_data_c;
         end
         wr_blocked_d = blocked_c;
      end
   end

   // State registers, synchronous reset folded into the next-state logic.
   always_ff @(posedge clock) begin
      for (int unsigned k = 0; k < NCELLS; k++) begin
         cells_q[k] <= cells_d[k];
      end
      wr_blocked_q <= wr_blocked_d;
   end

   // Flat board image straight from the cell registers.
   for (genvar g = 0; g < NCELLS; g++) begin : g_board
      assign board[CELL_W*g +: CELL_W] = cells_q[g];
   end

   // Combinational read port.
   always_comb begin
      rd_data = cells_q[rd_addr];
   end

   assign wr_blocked = wr_blocked_q;

endmodule

// File: tb/tb_board_memory.sv
// tb_board_memory: directed vector table plus randomized traffic against a
// cell-array reference model of board_memory.
module tb_board_memory;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CELL_W = 2;
   localparam int unsigned NCELLS = 256;
   localparam int unsigned BW     = 512;

`ifdef BOARD_MEMORY_OCCUPIED_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              we = 1'b0;
   logic [1:0]        player = 2'b00;
   logic              regret = 1'b0;
   logic [7:0]        wr_addr = 8'h00;
   logic [7:0]        rd_addr = 8'h00;
   logic [BW-1:0]     board;
   logic [1:0]        rd_data;
   logic              wr_blocked;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] model [NCELLS];
   bit         model_blk;

   board_memory #(.ADDR_W(ADDR_W), .CELL_W(CELL_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .we         (we),
      .player     (player),
      .regret     (regret),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .board      (board),
      .rd_data    (rd_data),
      .wr_blocked (wr_blocked)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         rst;
      bit         wen;
      bit         rg;
      logic [1:0] pl;
      logic [7:0] wa;
      logic [7:0] ra;
      bit         chk_pre;
      logic [1:0] exp_pre;
      logic [1:0] exp_post;
      bit         exp_blk;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] model_board();
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < int'(NCELLS); k++) b[2*k +: 2] = model[k];
      return b;
   endfunction

   // Reference behaviour of one clock edge, from the storage rules.
   task automatic model_edge(input bit r, input bit w, input bit rg, input logic [1:0] p,
                             input logic [7:0] wa);
      bit blk;
      if (r) begin
         for (int k = 0; k < int'(NCELLS); k++) model[k] = 2'b00;
         model_blk = 1'b0;
      end else begin
         blk = w && GUARD && !rg && (model[wa] != 2'b00);
         if (w && !blk) model[wa] = rg ? 2'b00 : p;
         model_blk = blk;
      end
   endtask

   // Apply one cycle: drive inputs, check the read before the edge, check state after.
   task automatic do_cycle(input bit r, input bit w, input bit rg, input logic [1:0] p,
                           input logic [7:0] wa, input logic [7:0] ra, input bit chk_pre,
                           output logic [1:0] rd_pre, output logic [1:0] rd_post,
                           output logic blk_post);
      reset = r; we = w; regret = rg; player = p; wr_addr = wa; rd_addr = ra;
      #1;
      rd_pre = rd_data;
      if (chk_pre) check("rd_pre_model", BW'(rd_pre), BW'(model[ra]));
      @(posedge clock);
      model_edge(r, w, rg, p, wa);
      #1;
      rd_post  = rd_data;
      blk_post = wr_blocked;
      check("board_model", board, model_board());
      check("blk_model", BW'(blk_post), BW'(model_blk));
      check("rd_post_model", BW'(rd_post), BW'(model[ra]));
   endtask

   initial begin
      logic [1:0] rp, rq;
      logic       bq;
      logic [BW-1:0] tmp;

      for (int k = 0; k < int'(NCELLS); k++) model[k] = 2'b00;
      model_blk = 1'b0;

      //          rst we rg  pl     wa     ra    pre pre_v  post_v                 blk
      vecs.push_back('{1, 0, 0, 2'b00, 8'h00, 8'h37, 0, 2'b00, 2'b00, 0});
      vecs.push_back('{0, 1, 0, 2'b01, 8'h37, 8'h37, 1, 2'b00, 2'b01, 0});
      vecs.push_back('{0, 1, 1, 2'b10, 8'h37, 8'h37, 1, 2'b01, 2'b00, 0});
      vecs.push_back('{0, 1, 0, 2'b10, 8'h00, 8'h00, 1, 2'b00, 2'b10, 0});
      vecs.push_back('{0, 1, 0, 2'b01, 8'hFF, 8'hFF, 1, 2'b00, 2'b01, 0});
      vecs.push_back('{0, 1, 0, 2'b11, 8'h5A, 8'h5A, 1, 2'b00, 2'b11, 0});
      vecs.push_back('{0, 0, 0, 2'b10, 8'h5A, 8'h5A, 1, 2'b11, 2'b11, 0});
      vecs.push_back('{0, 1, 0, 2'b01, 8'h10, 8'h10, 1, 2'b00, 2'b01, 0});
      vecs.push_back('{1, 1, 0, 2'b10, 8'h10, 8'h10, 1, 2'b01, 2'b00, 0});
      vecs.push_back('{0, 1, 0, 2'b01, 8'h22, 8'h22, 1, 2'b00, 2'b01, 0});
      vecs.push_back('{0, 1, 0, 2'b10, 8'h22, 8'h22, 1, 2'b01, GUARD ? 2'b01 : 2'b10, GUARD});
      vecs.push_back('{0, 0, 0, 2'b00, 8'h22, 8'h22, 1, GUARD ? 2'b01 : 2'b10, GUARD ? 2'b01 : 2'b10, 0});
      vecs.push_back('{0, 1, 1, 2'b01, 8'h22, 8'h22, 1, GUARD ? 2'b01 : 2'b10, 2'b00, 0});

      for (int i = 0; i < vecs.size(); i++) begin
         do_cycle(vecs[i].rst, vecs[i].wen, vecs[i].rg, vecs[i].pl, vecs[i].wa, vecs[i].ra,
                  vecs[i].chk_pre, rp, rq, bq);
         if (vecs[i].chk_pre) check($sformatf("vec%0d_rd_pre", i), BW'(rp), BW'(vecs[i].exp_pre));
         check($sformatf("vec%0d_rd_post", i), BW'(rq), BW'(vecs[i].exp_post));
         check($sformatf("vec%0d_blk", i), BW'(bq), BW'(vecs[i].exp_blk));
         if (i == 0) check("reset_board_zero", board, '0);
         if (i == 1) begin
            tmp = '0;
            tmp[111:110] = 2'b01;
            check("write37_board", board, tmp);
         end
         if (i == 2) check("regret37_board_zero", board, '0);
         if (i == 4) begin
            check("cell00_lsb", BW'(board[1:0]), BW'(2'b10));
            check("cellFF_msb", BW'(board[511:510]), BW'(2'b01));
         end
         if (i == 8) check("reset_vs_write_board", board, '0);
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         do_cycle(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 5) == 0),
                  2'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? wr_addr : 8'($urandom),
                  1'b1, rp, rq, bq);
      end

      // Fill with random writes, then reset and sweep every read address.
      for (int i = 0; i < 64; i++) begin
         do_cycle(1'b0, 1'b1, 1'b0, 2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
                  1'b1, rp, rq, bq);
      end
      do_cycle(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, rp, rq, bq);
      check("sweep_board_zero", board, '0);
      reset = 1'b0;
      for (int a = 0; a < int'(NCELLS); a++) begin
         rd_addr = 8'(a);
         #1;
         check($sformatf("sweep_rd_%02h", a), BW'(rd_data), '0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/board_memory.md
BOARD_MEMORY -- requirements
Module: board_memory

Interface
REQ-001 SHALL expose parameter ADDR_W, default 8; cell-address width, giving 2^ADDR_W cells (256 by default).
REQ-002 SHALL expose parameter CELL_W, default 2; bits per cell.
REQ-003 SHALL have port clock, input, 1, the single clock; every register updates on its rising edge only.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port we, input, 1; write enable, sampled on the clock edge.
REQ-006 SHALL have port player, input, CELL_W; write value when not clearing: 00 empty, 01 black, 10 white.
REQ-007 SHALL have port regret, input, 1; write-data select, 1 = write 00 (undo), 0 = write player.
REQ-008 SHALL have port wr_addr, input, ADDR_W; write cell = {y[3:0], x[3:0]}.
REQ-009 SHALL have port rd_addr, input, ADDR_W; read cell address, same encoding as wr_addr.
REQ-010 SHALL have port board, output, CELL_W*2^ADDR_W (512); flat image of all cells.
REQ-011 SHALL have port rd_data, output, CELL_W; content of cell rd_addr.
REQ-012 SHALL have port wr_blocked, output, 1; registered one-cycle pulse for a write suppressed by the occupancy guard.

Function
REQ-013 SHALL store cell k at board[CELL_W*k+CELL_W-1 : CELL_W*k], with cell 0 in the LSBs.
REQ-014 SHALL derive write data combinationally as wr_data = regret ? 00 : player (2:1, CELL_W-wide mux).
REQ-015 SHALL, on a clock edge with we=1 and reset=0, load wr_data into cell wr_addr; all other cells hold.
REQ-016 SHALL hold every cell on a clock edge with we=0.
REQ-017 SHALL drive board directly from the cell registers, with no extra pipeline stage.
REQ-018 SHALL drive rd_data combinationally from the cell registers; it is valid in the same cycle rd_addr changes.
REQ-019 SHALL show the old value on rd_data when rd_addr = wr_addr during a write cycle, and the new value after the edge (no write-through).
REQ-020 SHALL store value 11 unchanged if it is presented; no legality filtering (unless REQ-025 applies).
REQ-021 SHALL update exactly one cell per write; there is no address wrap-around because every ADDR_W value is a valid cell.
REQ-022 SHALL hold wr_blocked at 0 except as defined in REQ-025.

Reset
REQ-023 SHALL, on a clock edge with reset=1, clear all cells to 00 and clear wr_blocked to 0; board = 0 and rd_data = 00 after that edge.
REQ-024 SHALL give reset priority over a simultaneous write; reset asserted mid-game discards the pending write.

Configuration
REQ-025 SHALL, with macro BOARD_MEMORY_OCCUPIED_GUARD_EN defined, suppress any write with regret=0 to a cell whose current content is non-zero; the cell is unchanged and wr_blocked=1 for the following cycle. Writes with regret=1 are always performed.
REQ-026 SHALL, without BOARD_MEMORY_OCCUPIED_GUARD_EN, perform every enabled write unconditionally, with wr_blocked tied to 0.

Verification
REQ-027 SHALL verify reset: assert reset 1 cycle after random writes -> board = 512'h0, rd_data = 00 for all 256 rd_addr.
REQ-028 SHALL verify write/read: we=1, regret=0, player=01, wr_addr=8'h37 -> next cycle board[111:110] = 01, rd_addr=8'h37 gives rd_data = 01, and all other bits are 0.
REQ-029 SHALL verify regret: after REQ-028, we=1, regret=1, player=10, wr_addr=8'h37 -> cell 8'h37 = 00, board = 0.
REQ-030 SHALL verify boundaries: write 10 to 8'h00 and 01 to 8'hFF -> board[1:0] = 10, board[511:510] = 01.
REQ-031 SHALL verify simultaneous events: reset=1 with we=1, player=01, wr_addr=8'h10 -> cell 8'h10 = 00; same-cycle read of the written address returns the old value.
REQ-032 SHALL verify the guard (macro defined): cell 8'h22 = 01, then write player=10 with regret=0 -> cell stays 01 and wr_blocked pulses 1 for one cycle; without the macro -> cell = 10 and wr_blocked = 0.
